// File: rtl/crc_codeword_serializer.sv
// crc_codeword_serializer
//   Sits after the parallel CRC generator. Captures the data word when the
//   generator is strobed (data_en) and the CRC it returns (crc_vld), then
//   shifts {data, crc} out serially, MSB first, under valid/ready.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   data_en             capture strobe (generator crc_en)
//   data_in_parallel    data word, sampled with data_en
//   crc_vld, crc_in     generator result, sampled with crc_vld
//   in_ready            high while IDLE (registered); busy = ~in_ready
//   ser_ready           downstream accepts the current bit
//   ser_data/ser_vld    serial bit and its valid
//   ser_sof/ser_eof     first / last bit of the codeword
//   err_overrun         data_en outside IDLE, word dropped (1-cycle pulse)
//   err_orphan          crc_vld in IDLE without data_en (1-cycle pulse)
//   err_timeout         no crc_vld within TIMEOUT cycles (1-cycle pulse)
module crc_codeword_serializer #(
  parameter int CRC_WIDTH  = 4,
  parameter int DATA_WIDTH = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_en,
  input  logic [DATA_WIDTH-1:0] data_in_parallel,
  input  logic                  crc_vld,
  input  logic [CRC_WIDTH-1:0]  crc_in,
  output logic                  in_ready,
  input  logic                  ser_ready,
  output logic                  ser_data,
  output logic                  ser_vld,
  output logic                  ser_sof,
  output logic                  ser_eof,
  output logic                  busy,
  output logic                  err_overrun,
  output logic                  err_orphan,
  output logic                  err_timeout
);
  localparam int N  = DATA_WIDTH + CRC_WIDTH;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, WAIT_CRC, SHIFT} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [N-1:0]          shreg, shreg_nxt;
  logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
  logic [7:0]            to_cnt, to_cnt_nxt;
  logic                  ovr_nxt, orph_nxt, tmo_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      data_q      <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      in_ready    <= 1'b1;
      err_overrun <= 1'b0;
      err_orphan  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      data_q      <= data_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      in_ready    <= (state_nxt == IDLE);
      err_overrun <= ovr_nxt;
      err_orphan  <= orph_nxt;
      err_timeout <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    data_nxt    = data_q;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    to_cnt_nxt  = to_cnt;
    ovr_nxt     = 1'b0;
    orph_nxt    = 1'b0;
    tmo_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (data_en) begin
          data_nxt = data_in_parallel;
          if (crc_vld) begin
            shreg_nxt   = {data_in_parallel, crc_in};
            bit_cnt_nxt = '0;
            state_nxt   = SHIFT;
          end else begin
            to_cnt_nxt = '0;
            state_nxt  = WAIT_CRC;
          end
        end else if (crc_vld) begin
          orph_nxt = 1'b1;
        end
      end
      WAIT_CRC: begin
        // crc_vld wins over expiry in the same cycle
        if (crc_vld) begin
          shreg_nxt   = {data_q, crc_in};
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
          if (to_cnt + 8'd1 == 8'(TIMEOUT)) begin
            tmo_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          shreg_nxt = {shreg[N-2:0], 1'b0};
          if (bit_cnt == CW'(N-1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // a word offered while we are not idle is dropped, state untouched
    if (data_en && state != IDLE) ovr_nxt = 1'b1;
  end

  // Outputs decode straight from flops, so they hold through stalls.
  assign ser_vld  = (state == SHIFT);
  assign ser_data = ser_vld & shreg[N-1];
  assign ser_sof  = ser_vld && (bit_cnt == '0);
  assign ser_eof  = ser_vld && (bit_cnt == CW'(N-1));
  assign busy     = ~in_ready;

endmodule
